// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises rx, times each bit with a baud counter,
// assembles an 8N1 frame LSB first and offers the byte through valid/ready.
module uart_rx_ctrl #(
    parameter int BAUD_DIV  = 5208,
    parameter int SAMPLE_AT = BAUD_DIV / 2,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_AT);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [BW-1:0]        bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 sync1, rx_s, rx_prev;
    logic                 deliver, deliver_next;
    logic                 frame_err_next;
    logic                 bit_end, mid_bit;

    assign bit_end = (cnt == CNT_LAST);
    assign mid_bit = (cnt == CNT_SAMPLE);

    always_comb begin
        state_next     = state;
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        deliver_next   = 1'b0;
        frame_err_next = 1'b0;
        cnt_next       = cnt + 1'b1;
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) state_next = START;
            end
            START: begin
                if (mid_bit && rx_s) begin
                    state_next = IDLE;
                end else if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (mid_bit) shift_next = {rx_s, shift[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_idx == BIT_LAST) state_next = STOP;
                    else bit_idx_next = bit_idx + 1'b1;
                end
            end
            // Leaving at mid-stop gives half a bit of slack before the next start edge.
            STOP: begin
                if (mid_bit) begin
                    if (rx_s) begin
                        state_next   = IDLE;
                        deliver_next = 1'b1;
                    end else begin
                        state_next     = BRK;
                        frame_err_next = 1'b1;
                    end
                end
            end
            BRK: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state || bit_end || state == IDLE) cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            deliver   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync1     <= rx;
            rx_s      <= sync1;
            rx_prev   <= rx_s;
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            deliver   <= deliver_next;
            frame_err <= frame_err_next;
            busy      <= (state_next != IDLE);
            overrun   <= deliver && rx_valid && !rx_ready;
            // A byte may replace the held one only when the consumer takes it this cycle.
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a timeline model of the receiver checked every cycle,
// plus directed frames with hand-computed expectations.
module tb_uart_rx_ctrl;

    localparam int B = 16;
    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.BAUD_DIV(B), .SAMPLE_AT(S), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: elapsed-cycle timeline of a frame after the synchronised start edge
    logic       m_s1 = 1'b1, m_s2 = 1'b1, m_prev = 1'b1;
    logic       m_active = 1'b0, m_brk = 1'b0, m_pend = 1'b0;
    int         m_t = 0;
    logic [7:0] m_acc = 8'h00, m_data = 8'h00;
    logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 <= 1'b1; m_s2 <= 1'b1; m_prev <= 1'b1;
            m_active <= 1'b0; m_brk <= 1'b0; m_pend <= 1'b0; m_t <= 0;
            m_acc <= 8'h00; m_data <= 8'h00;
            m_valid <= 1'b0; m_ferr <= 1'b0; m_ovr <= 1'b0;
        end else begin
            m_s1 <= rx; m_s2 <= m_s1; m_prev <= m_s2;
            m_ferr <= 1'b0; m_ovr <= 1'b0; m_pend <= 1'b0;
            if (m_pend) begin
                if (!m_valid || rx_ready) begin
                    m_data  <= m_acc;
                    m_valid <= 1'b1;
                end else begin
                    m_ovr <= 1'b1;
                end
            end else if (m_valid && rx_ready) begin
                m_valid <= 1'b0;
            end
            if (m_brk) begin
                if (m_s2) m_brk <= 1'b0;
            end else if (!m_active) begin
                if (m_prev && !m_s2) begin
                    m_active <= 1'b1;
                    m_t      <= 0;
                end
            end else begin
                m_t <= m_t + 1;
                if (m_t == S && m_s2) begin
                    m_active <= 1'b0;
                end else if (m_t >= B && m_t < 9 * B && (m_t % B) == S) begin
                    m_acc[3'((m_t / B) - 1)] <= m_s2;
                end else if (m_t == 9 * B + S) begin
                    m_active <= 1'b0;
                    if (m_s2) m_pend <= 1'b1;
                    else begin
                        m_ferr <= 1'b1;
                        m_brk  <= 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput("rx_valid", rx_valid, m_valid);
            checkOutput("rx_data", rx_data, m_data);
            checkOutput("frame_err", frame_err, m_ferr);
            checkOutput("overrun", overrun, m_ovr);
            checkOutput("busy", busy, m_active || m_brk);
        end
    end

    int validCycles = 0, busyCycles = 0, accCount = 0, ferrCount = 0, ovrCount = 0;
    logic [7:0] lastAcc = 8'h00;

    always @(negedge clk) begin
        validCycles <= validCycles + int'(rx_valid === 1'b1);
        busyCycles  <= busyCycles + int'(busy === 1'b1);
        ferrCount   <= ferrCount + int'(frame_err === 1'b1);
        ovrCount    <= ovrCount + int'(overrun === 1'b1);
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            accCount <= accCount + 1;
            lastAcc  <= rx_data;
        end
    end

    int sValid, sBusy, sAcc, sFerr, sOvr;

    task automatic snap();
        sValid = validCycles; sBusy = busyCycles; sAcc = accCount;
        sFerr = ferrCount; sOvr = ovrCount;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives one 10-bit frame; optionally raises rx_ready exactly on the delivery
    // cycle, and optionally pulses rst at a given cycle offset into the frame.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input logic readyOnDeliver, input int rstAt);
        logic v;
        for (int b = 0; b < 10; b++) begin
            if (b == 0) v = 1'b0;
            else if (b == 9) v = stopBit;
            else v = data[b-1];
            for (int c = 0; c < B; c++) begin
                rx = v;
                if (readyOnDeliver) rx_ready = m_pend;
                rst = (b * B + c == rstAt);
                tick();
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
        idle(3);
        checkOutput("reset_valid", rx_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_data", rx_data, 0);
        checkOutput("reset_ferr", frame_err, 0);
        rst = 1'b0;
        idle(5);

        $display("[TB] test 1: frame 0x55 with rx_ready=1");
        rx_ready = 1'b1;
        snap();
        applyStimulus(8'h55, 1'b1, 1'b0, -1);
        idle(20);
        checkOutput("t1_accepts", accCount - sAcc, 1);
        checkOutput("t1_byte", lastAcc, 8'h55);
        checkOutput("t1_valid_cycles", validCycles - sValid, 1);
        checkOutput("t1_ferr", ferrCount - sFerr, 0);
        checkOutput("t1_model_byte", m_data, 8'h55);

        $display("[TB] test 2: 4-cycle glitch");
        snap();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        checkOutput("t2_busy_cycles", busyCycles - sBusy, 9);
        checkOutput("t2_valid_cycles", validCycles - sValid, 0);
        checkOutput("t2_ferr", ferrCount - sFerr, 0);

        $display("[TB] test 3: 0xC3 with stop bit 0, line held low");
        snap();
        applyStimulus(8'hC3, 1'b0, 1'b0, -1);
        rx = 1'b0;
        idle(40);
        checkOutput("t3_busy_in_break", busy, 1);
        rx = 1'b1;
        idle(10);
        checkOutput("t3_busy_after", busy, 0);
        checkOutput("t3_ferr_pulses", ferrCount - sFerr, 1);
        checkOutput("t3_valid_cycles", validCycles - sValid, 0);
        checkOutput("t3_accepts", accCount - sAcc, 0);

        $display("[TB] test 4: 0xA3, 0x3C back-to-back with rx_ready=0");
        rx_ready = 1'b0;
        snap();
        applyStimulus(8'hA3, 1'b1, 1'b0, -1);
        applyStimulus(8'h3C, 1'b1, 1'b0, -1);
        idle(20);
        checkOutput("t4_overruns", ovrCount - sOvr, 1);
        checkOutput("t4_held_byte", rx_data, 8'hA3);
        checkOutput("t4_valid", rx_valid, 1);
        checkOutput("t4_model_byte", m_data, 8'hA3);

        $display("[TB] test 5: accept coincident with delivery");
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        snap();
        applyStimulus(8'h5A, 1'b1, 1'b0, -1);
        applyStimulus(8'h3C, 1'b1, 1'b1, -1);
        rx_ready = 1'b0;
        idle(10);
        checkOutput("t5_byte", rx_data, 8'h3C);
        checkOutput("t5_valid", rx_valid, 1);
        checkOutput("t5_overruns", ovrCount - sOvr, 0);
        checkOutput("t5_accepts", accCount - sAcc, 1);
        checkOutput("t5_accepted_byte", lastAcc, 8'h5A);

        $display("[TB] test 6: reset during data bit 4 of 0xFF, then 0x0F");
        rx_ready = 1'b1;
        idle(2);
        snap();
        applyStimulus(8'hFF, 1'b1, 1'b0, 5 * B + S);
        idle(30);
        applyStimulus(8'h0F, 1'b1, 1'b0, -1);
        idle(20);
        checkOutput("t6_accepts", accCount - sAcc, 1);
        checkOutput("t6_byte", lastAcc, 8'h0F);
        checkOutput("t6_valid_cycles", validCycles - sValid, 1);
        checkOutput("t6_ferr", ferrCount - sFerr, 0);
        checkOutput("t6_overruns", ovrCount - sOvr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
